// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and types for the lfsr_rng block.
//   - Known maximal-length Galois tap masks for common widths.
//   - FSM state type used by lfsr_rng (FILL while stepping, VALID while
//     presenting a word).
package lfsr_pkg;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
  localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
  localparam logic [31:0] LFSR_TAPS_32 = 32'hA3000000;

  typedef enum logic {
    FILL  = 1'b0,
    VALID = 1'b1
  } lfsr_state_e;

endpackage

// File: rtl/lfsr_galois_step.sv
// lfsr_galois_step: combinational next state for one right-shifting Galois
// LFSR step. The bit shifted out of bit 0 selects whether TAPS is XORed in.
// Ports:
//   state_i  in  WIDTH  current state
//   state_o  out WIDTH  state after one step
module lfsr_galois_step #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hD008
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  assign state_o = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_rng.sv
// lfsr_rng: parametrised Galois LFSR random-word source with a valid/ready
// output handshake, step enable and seed load with all-zero protection.
// The LFSR advances STEPS times (in FILL) between words, then holds the word
// (in VALID) until the consumer takes it.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      step enable (handshake unaffected)
//   ld_en      in   1      load pulse, highest priority
//   ld_seed    in   WIDTH  seed to load; zero substitutes SEED
//   rnd_valid  out  1      rnd_data holds a fresh word
//   rnd_ready  in   1      consumer accepts the word
//   rnd_data   out  WIDTH  registered LFSR state
// Optional (macro LFSR_PERIOD_CHK_EN):
//   period_wrap out 1      one-cycle pulse when a step lands on the last seed
//   period_cnt  out 32     steps since the last seed event
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ld_en,
  input  logic [WIDTH-1:0] ld_seed,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [WIDTH-1:0] rnd_data
`ifdef LFSR_PERIOD_CHK_EN
  ,
  output logic             period_wrap,
  output logic [31:0]      period_cnt
`endif
);

  // Parameter legality is checked at elaboration.
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_rng: WIDTH must be in 3..32");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_rng: STEPS must be in 1..WIDTH");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_rng: SEED must be nonzero");
  end

  localparam int CNT_W = (STEPS < 2) ? 1 : $clog2(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  lfsr_state_e      fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_fire;

  lfsr_galois_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .state_i (state_q),
    .state_o (step_val)
  );

  // A zero seed would lock the LFSR; fall back to SEED.
  assign load_val  = (ld_seed == '0) ? SEED : ld_seed;
  // A step actually commits only when a load does not override it.
  assign step_fire = (fsm_q == FILL) && en && !ld_en;

  always_comb begin
    state_d = state_q;
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      FILL: begin
        if (en) begin
          state_d = step_val;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            fsm_d = VALID;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      VALID: begin
        if (rnd_ready) begin
          fsm_d = FILL;
          cnt_d = '0;
        end
      end
      default: fsm_d = FILL;
    endcase
    // Load wins over everything; a coincident handshake still counts as
    // transferred since the consumer saw valid && ready this cycle.
    if (ld_en) begin
      state_d = load_val;
      fsm_d   = FILL;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
      fsm_q   <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rnd_valid = (fsm_q == VALID);
  assign rnd_data  = state_q;

`ifdef LFSR_PERIOD_CHK_EN
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             wrap_q, wrap_d;
  logic [31:0]      pcnt_q, pcnt_d;

  // period_cnt reads N together with the wrap pulse of an N-step period;
  // the next step after sitting on the seed restarts the count at 1.
  always_comb begin
    seed_d = seed_q;
    wrap_d = 1'b0;
    pcnt_d = pcnt_q;
    if (ld_en) begin
      seed_d = load_val;
      pcnt_d = '0;
    end else if (step_fire) begin
      pcnt_d = (state_q == seed_q) ? 32'd1 : pcnt_q + 32'd1;
      wrap_d = (step_val == seed_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q <= SEED;
      wrap_q <= 1'b0;
      pcnt_q <= '0;
    end else begin
      seed_q <= seed_d;
      wrap_q <= wrap_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign period_wrap = wrap_q;
  assign period_cnt  = pcnt_q;
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
module tb_lfsr_rng;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  // default instance (WIDTH 16, STEPS 1)
  logic en0 = 0, ld0 = 0, rdy0 = 0, vld0;
  logic [15:0] seed0 = 0, data0;
  // STEPS 4
  logic en4 = 0, ld4 = 0, rdy4 = 0, vld4;
  logic [15:0] seed4 = 0, data4;
  // STEPS 8
  logic en8 = 0, ld8 = 0, rdy8 = 0, vld8;
  logic [15:0] seed8 = 0, data8;
  // WIDTH 4
  logic enw = 0, ldw = 0, rdyw = 0, vldw;
  logic [3:0] seedw = 0, dataw;
`ifdef LFSR_PERIOD_CHK_EN
  logic pw0, pw4, pw8, pww;
  logic [31:0] pc0, pc4, pc8, pcw;
`endif

  lfsr_rng u0 (.clk(clk), .rst_n(rst_n), .en(en0), .ld_en(ld0), .ld_seed(seed0),
    .rnd_valid(vld0), .rnd_ready(rdy0), .rnd_data(data0)
`ifdef LFSR_PERIOD_CHK_EN
    , .period_wrap(pw0), .period_cnt(pc0)
`endif
  );

  lfsr_rng #(.STEPS(4)) u4 (.clk(clk), .rst_n(rst_n), .en(en4), .ld_en(ld4), .ld_seed(seed4),
    .rnd_valid(vld4), .rnd_ready(rdy4), .rnd_data(data4)
`ifdef LFSR_PERIOD_CHK_EN
    , .period_wrap(pw4), .period_cnt(pc4)
`endif
  );

  lfsr_rng #(.STEPS(8)) u8 (.clk(clk), .rst_n(rst_n), .en(en8), .ld_en(ld8), .ld_seed(seed8),
    .rnd_valid(vld8), .rnd_ready(rdy8), .rnd_data(data8)
`ifdef LFSR_PERIOD_CHK_EN
    , .period_wrap(pw8), .period_cnt(pc8)
`endif
  );

  lfsr_rng #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .STEPS(1)) uw (.clk(clk), .rst_n(rst_n),
    .en(enw), .ld_en(ldw), .ld_seed(seedw), .rnd_valid(vldw), .rnd_ready(rdyw), .rnd_data(dataw)
`ifdef LFSR_PERIOD_CHK_EN
    , .period_wrap(pww), .period_cnt(pcw)
`endif
  );

  // Reference Galois step, masked to w bits.
  function automatic logic [31:0] gstep(input logic [31:0] s, input int w, input logic [31:0] taps);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return ((s >> 1) ^ (s[0] ? taps : 32'd0)) & mask;
  endfunction

  function automatic logic [31:0] gsteps(input logic [31:0] s, input int n);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = gstep(r, 16, 32'hD008);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    en0 = 0; ld0 = 0; rdy0 = 0; en4 = 0; rdy4 = 0; en8 = 0; rdy8 = 0;
    enw = 0; rdyw = 0; ldw = 0;
    sb.delete();
    tick();
    tick();
  endtask

  task automatic test_reset();
    hold_reset();
    n_chk++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL reset_vld0: got %b want 0", vld0); end
    n_chk++; if (data0 !== 16'hACE1) begin n_fail++; $display("FAIL reset_data0: got %h want ace1", data0); end
    n_chk++; if (vld4 !== 1'b0) begin n_fail++; $display("FAIL reset_vld4: got %b want 0", vld4); end
    n_chk++; if (dataw !== 4'h1) begin n_fail++; $display("FAIL reset_dataw: got %h want 1", dataw); end
  endtask

  task automatic test_first_word();
    logic [31:0] e;
    hold_reset();
    sb.push_back(gsteps(32'hACE1, 1));
    rst_n = 1'b1; en0 = 1'b1;
    tick();
    n_chk++; if (vld0 !== 1'b1) begin n_fail++; $display("FAIL first_vld: got %b want 1", vld0); end
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD;
    n_chk++; if (data0 !== e[15:0]) begin n_fail++; $display("FAIL first_data: got %h want %h", data0, e[15:0]); end
    n_chk++; if (data0 !== 16'h8678) begin n_fail++; $display("FAIL first_data_const: got %h want 8678", data0); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (vld0 !== 1'b1 || data0 !== 16'h8678) begin
        n_fail++; $display("FAIL hold[%0d]: got vld=%b data=%h want vld=1 data=8678", i, vld0, data0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    sb.push_back(gsteps(32'h8678, 1));
    rdy0 = 1'b1;
    tick();
    rdy0 = 1'b0;
    n_chk++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL hs_drop: got %b want 0", vld0); end
    tick();
    n_chk++; if (vld0 !== 1'b1) begin n_fail++; $display("FAIL hs_next_vld: got %b want 1", vld0); end
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD;
    n_chk++; if (data0 !== e[15:0]) begin n_fail++; $display("FAIL hs_next_data: got %h want %h", data0, e[15:0]); end
  endtask

  task automatic test_load_zero();
    logic [31:0] e;
    sb.push_back(gsteps(32'hACE1, 1));
    ld0 = 1'b1; seed0 = 16'h0; rdy0 = 1'b1;
    tick();
    ld0 = 1'b0; rdy0 = 1'b0;
    n_chk++; if (vld0 !== 1'b0 || data0 !== 16'hACE1) begin
      n_fail++; $display("FAIL load_zero: got vld=%b data=%h want vld=0 data=ace1", vld0, data0);
    end
    tick();
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD;
    n_chk++; if (vld0 !== 1'b1 || data0 !== e[15:0]) begin
      n_fail++; $display("FAIL load_next: got vld=%b data=%h want vld=1 data=%h", vld0, data0, e[15:0]);
    end
    // nonzero load is taken verbatim
    sb.push_back(gsteps(32'h1234, 1));
    ld0 = 1'b1; seed0 = 16'h1234;
    tick();
    ld0 = 1'b0;
    n_chk++; if (vld0 !== 1'b0 || data0 !== 16'h1234) begin
      n_fail++; $display("FAIL load_val: got vld=%b data=%h want vld=0 data=1234", vld0, data0);
    end
    tick();
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD;
    n_chk++; if (data0 !== e[15:0]) begin n_fail++; $display("FAIL load_val_next: got %h want %h", data0, e[15:0]); end
  endtask

  task automatic test_steps4_en_toggle();
    logic [31:0] e;
    int first;
    hold_reset();
    sb.push_back(gsteps(32'hACE1, 4));
    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      en4 = i[0] ? 1'b0 : 1'b1;   // enabled on even edges: 2,4,6,8
      tick();
      if (vld4 === 1'b1) first = i;
    end
    en4 = 1'b0;
    n_chk++; if (first != 8) begin n_fail++; $display("FAIL steps4_latency: got %0d want 8", first); end
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD;
    n_chk++; if (data4 !== e[15:0]) begin n_fail++; $display("FAIL steps4_data: got %h want %h", data4, e[15:0]); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] e;
    int first;
    hold_reset();
    rst_n = 1'b1; en8 = 1'b1;
    repeat (5) tick();
    n_chk++; if (vld8 !== 1'b0 || data8 !== gsteps(32'hACE1, 5)) begin
      n_fail++; $display("FAIL midfill_pre: got vld=%b data=%h want vld=0 data=%h", vld8, data8, gsteps(32'hACE1, 5));
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (vld8 !== 1'b0 || data8 !== 16'hACE1) begin
      n_fail++; $display("FAIL async_reset: got vld=%b data=%h want vld=0 data=ace1", vld8, data8);
    end
    tick();
    sb.push_back(gsteps(32'hACE1, 8));
    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      tick();
      if (vld8 === 1'b1) first = i;
    end
    n_chk++; if (first != 8) begin n_fail++; $display("FAIL steps8_latency: got %0d want 8", first); end
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD;
    n_chk++; if (data8 !== e[15:0]) begin n_fail++; $display("FAIL steps8_data: got %h want %h", data8, e[15:0]); end
    en8 = 1'b0;
  endtask

  task automatic test_period_w4();
    logic [31:0] m, e;
    int words;
    int zeros;
    int wraps;
    hold_reset();
    m = 32'h1;
    for (int i = 0; i < 20; i++) begin
      m = gstep(m, 4, 32'hC);
      sb.push_back(m);
    end
    rst_n = 1'b1; enw = 1'b1; rdyw = 1'b1;
    words = 0; zeros = 0; wraps = 0;
    for (int c = 0; c < 100 && words < 20; c++) begin
      tick();
      if (dataw === 4'h0) zeros++;
      if (vldw === 1'b1) begin
        words++;
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD;
        n_chk++; if (dataw !== e[3:0]) begin
          n_fail++; $display("FAIL w4_word[%0d]: got %h want %h", words, dataw, e[3:0]);
        end
      end
`ifdef LFSR_PERIOD_CHK_EN
      if (pww === 1'b1) begin
        wraps++;
        n_chk++; if (words != 15 || pcw !== 32'd15 || dataw !== 4'h1) begin
          n_fail++; $display("FAIL w4_wrap: got words=%0d cnt=%0d data=%h want 15 15 1", words, pcw, dataw);
        end
      end
`endif
    end
    enw = 1'b0; rdyw = 1'b0;
    n_chk++; if (words != 20) begin n_fail++; $display("FAIL w4_timeout: got %0d words want 20", words); end
    n_chk++; if (zeros != 0) begin n_fail++; $display("FAIL w4_zero_state: got %0d zero samples want 0", zeros); end
`ifdef LFSR_PERIOD_CHK_EN
    n_chk++; if (wraps != 1) begin n_fail++; $display("FAIL w4_wrap_count: got %0d want 1", wraps); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_back_to_back();
    test_load_zero();
    test_steps4_en_toggle();
    test_reset_mid_fill();
    test_period_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Parametrised Galois LFSR random-word source; successor to the fixed 16-bit game LFSR.
- Generalises width, tap polynomial and steps-per-word.
- Adds:
  - a valid/ready output handshake, so consumers (bomb/powerup placement, AI movement) pull words;
  - a step enable;
  - seed load with all-zero lockup protection.

Parameters:
- WIDTH, 16, state/output width; legal 3..32.
- TAPS, 16'hD008, Galois tap mask, WIDTH bits; bit i set means XOR feedback into bit i. Default equals x^16+x^15+x^13+x^4+1.
- SEED, 16'hACE1, reset and substitute state; must be nonzero (elaboration error if zero).
- STEPS, 1, LFSR shifts between consecutive output words; legal 1..WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  step enable; when low, no shifting occurs (handshake still works)
- ld_en  in  1  load pulse, active high
- ld_seed  in  WIDTH  seed value, sampled when ld_en=1
- rnd_valid  out  1  rnd_data holds a fresh word
- rnd_ready  in  1  consumer accepts word
- rnd_data  out  WIDTH  current LFSR state

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - On reset: state=SEED, fsm=FILL, step_cnt=0, rnd_valid=0, rnd_data=SEED.
- Galois step: fb=s[0]; s_next=(s>>1) ^ (fb ? TAPS : 0). Width is WIDTH throughout, with no carry or extension.
- FILL state:
  - Each cycle with en=1: perform one step and increment step_cnt.
  - When en=1 and step_cnt==STEPS-1: step, clear step_cnt, and go to VALID.
  - en=0: hold state and counter.
  - Latency: the first word is valid STEPS enabled cycles after reset release.
- VALID state:
  - rnd_valid=1; no stepping.
  - rnd_data is stable while rnd_valid && !rnd_ready.
  - On rnd_valid && rnd_ready: the word is transferred; go to FILL with step_cnt=0; rnd_valid=0 on the next cycle.
  - Maximum throughput is therefore one word per STEPS+1 cycles.
- rnd_ready while in FILL: ignored.
- Load (highest priority, any state):
  - ld_en=1 sets state=ld_seed, or SEED if ld_seed==0 (lockup protection).
  - fsm=FILL, step_cnt=0, rnd_valid=0 on the next cycle.
  - If a handshake coincides with load, the pre-load word counts as transferred.
- rnd_data is always the registered state; consumers must qualify it with rnd_valid.
- Zero state is unreachable: reset and load both guarantee a nonzero state, and the Galois step preserves nonzero.
- Reset asserted mid-FILL or mid-VALID aborts immediately to reset values; a pending word is discarded.

Optional Feature:
- Macro: LFSR_PERIOD_CHK_EN.
- With the macro defined:
  - Adds output period_wrap (1 bit). It is a one-cycle registered pulse when a step produces a state equal to the most recent seed: SEED after reset, or the substituted/loaded value after a load.
  - Adds output period_cnt (32 bits). It counts steps since the last seed event; cleared by reset/load; reloaded to 1 on wrap.
- Without the macro: neither port exists and there are no extra registers.

Decomposition:
- Package lfsr_pkg holds:
  - maximal-length tap constants LFSR_TAPS_8=8'hB8, LFSR_TAPS_16=16'hD008, LFSR_TAPS_24=24'hE10000, LFSR_TAPS_32=32'hA3000000;
  - the FSM state typedef (FILL, VALID).
- Sub-module lfsr_galois_step: combinational next-state for one step, parametrised WIDTH and TAPS. It is instantiated once; the top owns registers, FSM and counter.

Test Plan:
- Defaults, release rst_n, en=1, rnd_ready=0 -> after 1 cycle rnd_valid=1, rnd_data=16'h8678, held for 10 cycles.
- Defaults, pulse rnd_ready for one cycle while valid -> rnd_valid=0 the next cycle; the cycle after, rnd_valid=1 with rnd_data=Galois step of 16'h8678.
- STEPS=4, en toggled 1/0 each cycle -> first rnd_valid only after 4 enabled cycles (8 clocks). The word equals 4 steps from SEED in a reference model.
- ld_en=1, ld_seed=0 during VALID with rnd_ready=1 -> word accepted; state restarts from 16'hACE1; next word=16'h8678.
- WIDTH=4, TAPS=4'hC, SEED=4'h1, LFSR_PERIOD_CHK_EN defined, rnd_ready=1 -> period_wrap pulses after exactly 15 steps; period_cnt=15 at that step; no 4'h0 state is ever observed.
- Assert rst_n low mid-FILL (STEPS=8, step_cnt=5) -> rnd_valid=0 and rnd_data=SEED asynchronously; after release, the first word arrives 8 cycles later.
